lsu_mem_master: RTL and testbench

- Load/store initiator for the MEM stage of the pipelined core.
- Drives the word-addressed, async-read / sync-write data memory port: address, write data, write enable in; read data out.
- Converts RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. Sub-word stores use a single-cycle read-modify-write. Accesses that cross a word boundary are split into two word accesses.
- Raises busy so the hazard unit stalls the earlier stages while an access is in flight.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_mem_master_align.sv | 51 +++++
 rtl/lsu_mem_master.sv | 174 +++++++++++++++++
 tb/tb_lsu_mem_master.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU memory master: funct3 codes, FSM state encoding,
// and the access-size / legality helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC0 = 2'b01,
    ST_ACC1 = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] size_mask(input logic [1:0] size_code);
    logic [3:0] m;
    case (size_code)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Unsigned sub-word codes exist only for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_mem_master_align.sv
// Combinational lane logic: byte-enable window, store byte-lane merge over the
// current memory word, and load extract with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic        hi_lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  input  logic [63:0] ld_word_i,
  output logic [7:0]  be_o,
  output logic        cross_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [4:0]  bit_off_s;
  logic [63:0] st_shift_s;
  logic [31:0] ld_shift_s;

  assign bit_off_s  = {off_i, 3'b000};
  assign be_o       = {4'b0000, size_mask(funct3_i[1:0])} << off_i;
  assign cross_o    = |be_o[7:4];
  assign st_shift_s = {32'h0000_0000, wdata_i} << bit_off_s;
  assign ld_shift_s = 32'(ld_word_i >> bit_off_s);

  // Store merge: the high lane covers bytes 4..7 of the shifted window
  always_comb begin
    st_data_o = mem_rdata_i;
    for (int i = 0; i < 4; i++) begin
      if (hi_lane_i ? be_o[i+4] : be_o[i]) begin
        st_data_o[8*i +: 8] = hi_lane_i ? st_shift_s[32+8*i +: 8] : st_shift_s[8*i +: 8];
      end else begin
        st_data_o[8*i +: 8] = mem_rdata_i[8*i +: 8];
      end
    end
  end

  // Load extract and extend
  always_comb begin
    ld_data_o = 32'h0000_0000;
    case (funct3_i[1:0])
      2'b00:   ld_data_o = {{24{~funct3_i[2] & ld_shift_s[7]}}, ld_shift_s[7:0]};
      2'b01:   ld_data_o = {{16{~funct3_i[2] & ld_shift_s[15]}}, ld_shift_s[15:0]};
      2'b10:   ld_data_o = ld_shift_s;
      default: ld_data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store initiator: turns byte-addressed RV32I accesses into one or
// two word accesses on an async-read / sync-write memory port.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q, rdata_d;
  logic        resp_err_q, err_d;
  logic        busy_q;

  logic [ADDR_W-1:0] w0_s, w1_s, mem_addr_s;
  logic [31:0]       mem_wdata_s, st_data_s, ld_data_s;
  logic [63:0]       ld_word_s;
  logic [7:0]        be_s;
  logic              cross_s, mem_we_s;

  assign w0_s = addr_q[ADDR_W+1:2];
  assign w1_s = w0_s + {{(ADDR_W-1){1'b0}}, 1'b1};

  // The word being read this cycle is combined with the half captured earlier.
  assign ld_word_s = (state_q == ST_ACC1) ? {mem_rdata, lo_q} : {hi_q, mem_rdata};

  lsu_align u_align (
    .funct3_i    (f3_q),
    .off_i       (addr_q[1:0]),
    .hi_lane_i   (state_q == ST_ACC1),
    .wdata_i     (wdata_q),
    .mem_rdata_i (mem_rdata),
    .ld_word_i   (ld_word_s),
    .be_o        (be_s),
    .cross_o     (cross_s),
    .st_data_o   (st_data_s),
    .ld_data_o   (ld_data_s)
  );

  // Next-state, capture and memory-port control
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    rdata_d     = 32'h0000_0000;
    err_d       = 1'b0;
    mem_addr_s  = w0_s;
    mem_wdata_s = 32'h0000_0000;
    mem_we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (f3_legal(req_we, req_funct3)) begin
            state_d = ST_ACC0;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC0: begin
        mem_addr_s = w0_s;
        if (cross_s && (SPLIT_EN == 1'b0)) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end else begin
          if (we_q) begin
            mem_wdata_s = st_data_s;
            mem_we_s    = |be_s[3:0];
          end else begin
            lo_d = mem_rdata;
          end
          if (cross_s) begin
            state_d = ST_ACC1;
          end else begin
            state_d = ST_RESP;
            rdata_d = we_q ? 32'h0000_0000 : ld_data_s;
          end
        end
      end
      ST_ACC1: begin
        mem_addr_s = w1_s;
        if (we_q) begin
          mem_wdata_s = st_data_s;
          mem_we_s    = |be_s[7:4];
        end else begin
          hi_d = mem_rdata;
        end
        state_d = ST_RESP;
        rdata_d = we_q ? 32'h0000_0000 : ld_data_s;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, request capture and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      lo_q         <= 32'h0000_0000;
      hi_q         <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      resp_valid_q <= (state_d == ST_RESP);
      resp_rdata_q <= rdata_d;
      resp_err_q   <= err_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  assign mem_addr   = mem_addr_s;
  assign mem_wdata  = mem_wdata_s;
  assign mem_we     = mem_we_s & ~rst;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: instance A splits crossing accesses, instance B
// (SPLIT_EN=0, 16-word memory) flags them as errors.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid_a = 1'b0, req_valid_b = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_busy, a_mem_we;
  logic [31:0] a_resp_rdata, a_mem_wdata, a_mem_rdata;
  logic [13:0] a_mem_addr;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_busy, b_mem_we;
  logic [31:0] b_resp_rdata, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_addr;

  lsu_mem_master dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(a_req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy(a_busy),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_rdata(a_mem_rdata)
  );

  lsu_mem_master #(.ADDR_W(4), .DATA_W(32), .SPLIT_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(b_req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata)
  );

  logic [31:0] mem_a [0:16383];
  logic [31:0] mem_b [0:15];
  logic        pre_a = 1'b0, pre_b = 1'b0;
  logic [13:0] pre_idx = 14'h0;
  logic [31:0] pre_dat = 32'h0;

  assign a_mem_rdata = mem_a[a_mem_addr];
  assign b_mem_rdata = mem_b[b_mem_addr];

  always @(posedge clk) begin
    if (pre_a) mem_a[pre_idx] <= pre_dat;
    else if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    if (pre_b) mem_b[pre_idx[3:0]] <= pre_dat;
    else if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
  end

  logic        sel = 1'b0;
  logic        cur_ready, cur_resp_valid, cur_resp_err, cur_busy, cur_mem_we;
  logic [31:0] cur_resp_rdata;
  assign cur_ready      = sel ? b_req_ready : a_req_ready;
  assign cur_resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign cur_resp_err   = sel ? b_resp_err : a_resp_err;
  assign cur_resp_rdata = sel ? b_resp_rdata : a_resp_rdata;
  assign cur_busy       = sel ? b_busy : a_busy;
  assign cur_mem_we     = sel ? b_mem_we : a_mem_we;

  int checks = 0;
  int errors = 0;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Called and returns at a falling edge.
  task automatic preload(input bit which, input logic [13:0] idx, input logic [31:0] dat);
    pre_a = ~which; pre_b = which; pre_idx = idx; pre_dat = dat;
    @(posedge clk);
    @(negedge clk);
    pre_a = 1'b0; pre_b = 1'b0;
  endtask

  // lat counts cycles with the acceptance cycle as cycle 0; returns at the falling
  // edge of the response cycle.
  task automatic issue(input bit which, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output int wait_n, output int wes,
                       output logic [31:0] rd, output logic er, output logic bz,
                       output logic rdy_r);
    logic rdy;
    sel = which; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    if (which) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    lat = -1; wait_n = 0; wes = 0; rd = 32'h0; er = 1'b0; bz = 1'b0; rdy_r = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rdy = cur_ready;
      @(posedge clk);
      if (rdy) break;
      wait_n++;
      @(negedge clk);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin req_valid_a = 1'b0; req_valid_b = 1'b0; end
      if (cur_mem_we) wes++;
      if (cur_resp_valid) begin
        lat = k; rd = cur_resp_rdata; er = cur_resp_err; bz = cur_busy; rdy_r = cur_ready;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a_mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", a_mem_we); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", a_busy); end
    checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", a_resp_valid); end
    checks++; if (a_resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata got %h exp 0", a_resp_rdata); end
    checks++; if (a_resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err got %b exp 0", a_resp_err); end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", a_req_ready); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rst_b_busy got %b exp 0", b_busy); end
  endtask

  task automatic test_loads();
    int lat, wn, wes; logic [31:0] rd; logic er, bz, ry;
    preload(1'b0, 14'd0, 32'h9F5D4A6E);
    issue(1'b0, 1'b0, F3_W, 32'h0, 32'h0, lat, wn, wes, rd, er, bz, ry);
    checks++; if (rd !== 32'h9F5D4A6E) begin errors++; $display("FAIL lw_rdata got %h exp 9f5d4a6e", rd); end
    checks++; if (lat != 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", er); end
    checks++; if (bz !== 1'b1 || ry !== 1'b0) begin errors++; $display("FAIL lw_busy_ready got %b%b exp 10", bz, ry); end
    checks++; if (wes != 0) begin errors++; $display("FAIL lw_no_write got %0d exp 0", wes); end
    issue(1'b0, 1'b0, F3_B, 32'h3, 32'h0, lat, wn, wes, rd, er, bz, ry);
    checks++; if (rd !== 32'hFFFFFF9F) begin errors++; $display("FAIL lb_rdata got %h exp ffffff9f", rd); end
    issue(1'b0, 1'b0, F3_BU, 32'h3, 32'h0, lat, wn, wes, rd, er, bz, ry);
    checks++; if (rd !== 32'h0000009F) begin errors++; $display("FAIL lbu_rdata got %h exp 0000009f", rd); end
    issue(1'b0, 1'b0, F3_H, 32'h1, 32'h0, lat, wn, wes, rd, er, bz, ry);
    checks++; if (rd !== 32'h00005D4A) begin errors++; $display("FAIL lh_rdata got %h exp 00005d4a", rd); end
    checks++; if (lat != 2) begin errors++; $display("FAIL lh_latency got %0d exp 2", lat); end
  endtask

  task automatic test_sub_store();
    int lat, wn, wes; logic [31:0] rd; logic er, bz, ry;
    preload(1'b0, 14'd1, 32'h0000000E);
    issue(1'b0, 1'b1, F3_B, 32'h5, 32'h123456AB, lat, wn, wes, rd, er, bz, ry);
    checks++; if (mem_a[1] !== 32'h0000AB0E) begin errors++; $display("FAIL sb_word got %h exp 0000ab0e", mem_a[1]); end
    checks++; if (wes != 1) begin errors++; $display("FAIL sb_we_cycles got %0d exp 1", wes); end
    checks++; if (lat != 2) begin errors++; $display("FAIL sb_latency got %0d exp 2", lat); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sb_resp got %h/%b exp 0/0", rd, er); end
  endtask

  task automatic test_split_store();
    int lat, wn, wes; logic [31:0] rd; logic er, bz, ry;
    preload(1'b0, 14'd0, 32'h11223344);
    preload(1'b0, 14'd1, 32'h55667788);
    issue(1'b0, 1'b1, F3_W, 32'h2, 32'hDEADBEEF, lat, wn, wes, rd, er, bz, ry);
    checks++; if (mem_a[0] !== 32'hBEEF3344) begin errors++; $display("FAIL sw_split_w0 got %h exp beef3344", mem_a[0]); end
    checks++; if (mem_a[1] !== 32'h5566DEAD) begin errors++; $display("FAIL sw_split_w1 got %h exp 5566dead", mem_a[1]); end
    checks++; if (wes != 2) begin errors++; $display("FAIL sw_split_we_cycles got %0d exp 2", wes); end
    checks++; if (lat != 3) begin errors++; $display("FAIL sw_split_latency got %0d exp 3", lat); end
    issue(1'b0, 1'b0, F3_W, 32'h2, 32'h0, lat, wn, wes, rd, er, bz, ry);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_split_rdata got %h exp deadbeef", rd); end
    checks++; if (lat != 3) begin errors++; $display("FAIL lw_split_latency got %0d exp 3", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, wn, wes; logic [31:0] rd; logic er, bz, ry;
    issue(1'b0, 1'b0, F3_BU, 32'h0, 32'h0, lat, wn, wes, rd, er, bz, ry);
    checks++; if (rd !== 32'h00000044) begin errors++; $display("FAIL b2b_first got %h exp 00000044", rd); end
    issue(1'b0, 1'b0, F3_HU, 32'h2, 32'h0, lat, wn, wes, rd, er, bz, ry);
    checks++; if (wn != 1) begin errors++; $display("FAIL b2b_accept_wait got %0d exp 1", wn); end
    checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL b2b_second got %h exp 0000beef", rd); end
  endtask

  task automatic test_errors();
    int lat, wn, wes; logic [31:0] rd; logic er, bz, ry;
    issue(1'b0, 1'b0, 3'b011, 32'h0, 32'h0, lat, wn, wes, rd, er, bz, ry);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL ill_load got err %b rdata %h exp 1/0", er, rd); end
    checks++; if (wes != 0) begin errors++; $display("FAIL ill_load_we got %0d exp 0", wes); end
    issue(1'b0, 1'b1, F3_BU, 32'h0, 32'hFFFFFFFF, lat, wn, wes, rd, er, bz, ry);
    checks++; if (er !== 1'b1 || wes != 0) begin errors++; $display("FAIL ill_store got err %b we %0d exp 1/0", er, wes); end
    preload(1'b1, 14'd0, 32'h11223344);
    issue(1'b1, 1'b1, F3_W, 32'h2, 32'hDEADBEEF, lat, wn, wes, rd, er, bz, ry);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL nosplit_err got err %b rdata %h exp 1/0", er, rd); end
    checks++; if (wes != 0) begin errors++; $display("FAIL nosplit_we got %0d exp 0", wes); end
    checks++; if (mem_b[0] !== 32'h11223344) begin errors++; $display("FAIL nosplit_mem got %h exp 11223344", mem_b[0]); end
    checks++; if (lat != 2) begin errors++; $display("FAIL nosplit_latency got %0d exp 2", lat); end
    issue(1'b1, 1'b0, F3_H, 32'h2, 32'h0, lat, wn, wes, rd, er, bz, ry);
    checks++; if (er !== 1'b0 || rd !== 32'h00001122) begin errors++; $display("FAIL nosplit_lh got err %b rdata %h exp 0/00001122", er, rd); end
  endtask

  task automatic test_wrap();
    int lat, wn, wes; logic [31:0] rd; logic er, bz, ry;
    preload(1'b0, 14'h3FFF, 32'h80112233);
    preload(1'b0, 14'h0000, 32'h000000C5);
    issue(1'b0, 1'b0, F3_H, 32'h0000FFFF, 32'h0, lat, wn, wes, rd, er, bz, ry);
    checks++; if (rd !== 32'hFFFFC580) begin errors++; $display("FAIL wrap_lh got %h exp ffffc580", rd); end
    checks++; if (lat != 3) begin errors++; $display("FAIL wrap_latency got %0d exp 3", lat); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    preload(1'b0, 14'd0, 32'h11223344);
    preload(1'b0, 14'd1, 32'h55667788);
    sel = 1'b0; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h2; req_wdata = 32'hDEADBEEF;
    req_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (a_mem_we !== 1'b1 || a_mem_addr !== 14'd1) begin errors++; $display("FAIL mid_acc1 got we %b addr %h exp 1/0001", a_mem_we, a_mem_addr); end
    rst = 1'b1;
    #1;
    checks++; if (a_mem_we !== 1'b0) begin errors++; $display("FAIL mid_we_forced got %b exp 0", a_mem_we); end
    @(negedge clk);
    checks++; if (a_busy !== 1'b0 || a_req_ready !== 1'b1) begin errors++; $display("FAIL mid_idle got busy %b ready %b exp 0/1", a_busy, a_req_ready); end
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (a_resp_valid) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL mid_no_resp got %0d exp 0", pulses); end
    checks++; if (mem_a[0] !== 32'hBEEF3344) begin errors++; $display("FAIL mid_w0_kept got %h exp beef3344", mem_a[0]); end
    checks++; if (mem_a[1] !== 32'h55667788) begin errors++; $display("FAIL mid_w1_untouched got %h exp 55667788", mem_a[1]); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_sub_store();
    test_split_store();
    test_back_to_back();
    test_errors();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
